// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, coordinate type and a window helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   // Sync windows are half-open: [START, END)
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef logic [9:0] coord_t;

   // True when lo <= v < hi
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator and its consumers.
// Latency: n/a (wires only).
// Backpressure: consumer drives en; generator holds the raster while en=0.
interface vga_timing_gen_if #(
   parameter int FC_W = 16
);
   import vga_timing_pkg::*;

   logic            en;
   coord_t          DrawX;
   coord_t          DrawY;
   logic            blank;
   logic            hs;
   logic            vs;
   logic            line_start;
   logic            frame_start;
   logic [FC_W-1:0] frame_count;

   modport master (
      input  en,
      output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );

   modport slave (
      output en,
      input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
   );

endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-MOD up-counter with a wrap strobe (terminal count AND inc).
// Latency: count updates on the edge after inc; wrap_o is combinational.
// Backpressure: holds its value whenever inc_i is low.
module vga_wrap_counter #(
   parameter int MOD = 800,
   parameter int W   = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = inc_i && (cnt_q == LAST);
   assign cnt_o  = cnt_q;

   // Next count: advance on inc, return to zero after the last value
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, visible flag, syncs, line/frame strobes, frame count.
// Latency: every output is registered from the pre-update counters (one cycle behind them).
// Backpressure: en=0 freezes counters and outputs; strobes drop to 0 so none repeats.
module vga_timing_gen #(
   parameter int   H_VIS       = vga_timing_pkg::H_VIS,
   parameter int   H_FP        = vga_timing_pkg::H_FP,
   parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int   H_BP        = vga_timing_pkg::H_BP,
   parameter int   V_VIS       = vga_timing_pkg::V_VIS,
   parameter int   V_FP        = vga_timing_pkg::V_FP,
   parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int   V_BP        = vga_timing_pkg::V_BP,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   FC_W        = 16
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   vga_timing_gen_if.master  vif
);
   import vga_timing_pkg::*;

   localparam int     H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int     V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam coord_t H_VIS_C = coord_t'(H_VIS);
   localparam coord_t V_VIS_C = coord_t'(V_VIS);
   localparam coord_t HS_LO   = coord_t'(H_VIS + H_FP);
   localparam coord_t HS_HI   = coord_t'(H_VIS + H_FP + H_SYNC);
   localparam coord_t VS_LO   = coord_t'(V_VIS + V_FP);
   localparam coord_t VS_HI   = coord_t'(V_VIS + V_FP + V_SYNC);

   coord_t hc;
   coord_t vc;
   logic   h_wrap;
   logic   v_wrap;

   // Column counter advances on every enabled cycle
   vga_wrap_counter #(.MOD(H_TOT), .W(10)) u_hcnt (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .inc_i  (vif.en),
      .cnt_o  (hc),
      .wrap_o (h_wrap)
   );

   // Line counter advances once per completed line
   vga_wrap_counter #(.MOD(V_TOT), .W(10)) u_vcnt (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .inc_i  (h_wrap),
      .cnt_o  (vc),
      .wrap_o (v_wrap)
   );

   logic [FC_W-1:0] fc_q,     fc_d;
   coord_t          drawx_q,  drawx_d;
   coord_t          drawy_q,  drawy_d;
   logic            blank_q,  blank_d;
   logic            hs_q,     hs_d;
   logic            vs_q,     vs_d;
   logic            ls_q,     ls_d;
   logic            fs_q,     fs_d;
   logic [FC_W-1:0] fcnt_q,   fcnt_d;

   // Completed-frame counter, bumped when the last pixel of a frame is consumed
   always_comb begin
      fc_d = fc_q;
      if (v_wrap) begin
         fc_d = fc_q + 1'b1;
      end
   end

   // Decode the current (pre-update) position into next output values
   always_comb begin
      drawx_d = drawx_q;
      drawy_d = drawy_q;
      blank_d = blank_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      fcnt_d  = fcnt_q;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (vif.en) begin
         drawx_d = hc;
         drawy_d = vc;
         blank_d = (hc < H_VIS_C) && (vc < V_VIS_C);
         hs_d    = in_window(hc, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vs_d    = in_window(vc, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         fcnt_d  = fc_q;
         ls_d    = (hc == '0);
         fs_d    = (hc == '0) && (vc == '0);
      end
   end

   // Frame counter and output registers
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         fc_q    <= '0;
         drawx_q <= '0;
         drawy_q <= '0;
         blank_q <= 1'b0;
         hs_q    <= ~SYNC_ACTIVE;
         vs_q    <= ~SYNC_ACTIVE;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         fc_q    <= fc_d;
         drawx_q <= drawx_d;
         drawy_q <= drawy_d;
         blank_q <= blank_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign vif.DrawX       = drawx_q;
   assign vif.DrawY       = drawy_q;
   assign vif.blank       = blank_q;
   assign vif.hs          = hs_q;
   assign vif.vs          = vs_q;
   assign vif.line_start  = ls_q;
   assign vif.frame_start = fs_q;
   assign vif.frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a full-size 640x480 generator and a tiny-geometry one (FC_W=4, active-high sync)
// driven by the same en, checked each cycle against an arithmetic raster model,
// plus a startup vector table and hand-written line/hold/reset/wrap sequences.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        blank;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      int   hv, hfp, hsw, hbp;
      int   vv, vfp, vsw, vbp;
      logic sa;
      int   fcw;
   } geo_t;

   typedef struct {
      logic en;
      obs_t exp;
   } vec_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 vga_clk = ~vga_clk;

   vga_timing_gen_if #(.FC_W(16)) bif ();
   vga_timing_gen_if #(.FC_W(4))  sif ();

   vga_timing_gen u_big (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vif     (bif.master)
   );

   vga_timing_gen #(
      .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_ACTIVE(1'b1), .FC_W(4)
   ) u_sm (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vif     (sif.master)
   );

   geo_t GB = '{hv:640, hfp:16, hsw:96, hbp:48, vv:480, vfp:10, vsw:2, vbp:33, sa:1'b0, fcw:16};
   geo_t GS = '{hv:4,   hfp:1,  hsw:2,  hbp:1,  vv:3,   vfp:1,  vsw:1, vbp:1,  sa:1'b1, fcw:4};

   int   total = 0;
   int   bad   = 0;
   int   k     = 0;      // enabled edges since last reset release
   logic last_en = 1'b0;

   // Raster expectation from the pixel index: after k enabled edges pixel k-1 is shown
   function automatic obs_t model(geo_t g, int kk, logic le);
      obs_t o;
      int ht, vt, p, x, y, f;
      ht = g.hv + g.hfp + g.hsw + g.hbp;
      vt = g.vv + g.vfp + g.vsw + g.vbp;
      o = '0;
      o.hs = ~g.sa;
      o.vs = ~g.sa;
      if (kk == 0) return o;
      p = kk - 1;
      x = p % ht;
      y = (p / ht) % vt;
      f = (p / (ht * vt)) % (1 << g.fcw);
      o.x     = 10'(x);
      o.y     = 10'(y);
      o.blank = (x < g.hv) && (y < g.vv);
      o.hs    = (x >= g.hv + g.hfp && x < g.hv + g.hfp + g.hsw) ? g.sa : ~g.sa;
      o.vs    = (y >= g.vv + g.vfp && y < g.vv + g.vfp + g.vsw) ? g.sa : ~g.sa;
      o.ls    = le && (x == 0);
      o.fs    = le && (x == 0) && (y == 0);
      o.fc    = 16'(f);
      return o;
   endfunction

   function automatic obs_t mk(int x, int y, logic b, logic h, logic v, logic l, logic f, int fc);
      obs_t o;
      o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
      o.ls = l; o.fs = f; o.fc = 16'(fc);
      return o;
   endfunction

   function automatic obs_t samp_big();
      obs_t o;
      o.x = bif.DrawX; o.y = bif.DrawY; o.blank = bif.blank; o.hs = bif.hs; o.vs = bif.vs;
      o.ls = bif.line_start; o.fs = bif.frame_start; o.fc = bif.frame_count;
      return o;
   endfunction

   function automatic obs_t samp_sm();
      obs_t o;
      o.x = sif.DrawX; o.y = sif.DrawY; o.blank = sif.blank; o.hs = sif.hs; o.vs = sif.vs;
      o.ls = sif.line_start; o.fs = sif.frame_start; o.fc = {12'b0, sif.frame_count};
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                       o.x, o.y, o.blank, o.hs, o.vs, o.ls, o.fs, o.fc);
   endfunction

   task automatic check(string name, obs_t act, obs_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s k=%0d: got {%s} expected {%s}", name, k, fmt(act), fmt(exp));
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock with the given en, then model-check both generators
   task automatic tick(input logic e);
      bif.en = e;
      sif.en = e;
      @(posedge vga_clk);
      #1;
      if (e) k++;
      last_en = e;
      check("big", samp_big(), model(GB, k, last_en));
      check("small", samp_sm(), model(GS, k, last_en));
   endtask

   // Assert reset between edges and check that outputs clear without a clock
   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      k = 0;
      last_en = 1'b0;
      check("async_rst_big", samp_big(), model(GB, 0, 1'b0));
      check("async_rst_small", samp_sm(), model(GS, 0, 1'b0));
      @(posedge vga_clk);
      #1 reset_n = 1'b1;
   endtask

   vec_t tbl[11];

   initial begin
      int ls_cnt, ls_first, ls_second, blank_cnt, hs_cnt, hs_x, n, frozen_bad;
      int fs_cnt, vs_cnt, wrap_seen, prev_fc, guard;
      logic e;

      // Tiny geometry: H_TOTAL=8 (hs 5..6), V_TOTAL=6 (vs line 4), active-high sync
      tbl[0]  = '{en:1'b1, exp:mk(0, 0, 1, 0, 0, 1, 1, 0)};
      tbl[1]  = '{en:1'b1, exp:mk(1, 0, 1, 0, 0, 0, 0, 0)};
      tbl[2]  = '{en:1'b0, exp:mk(1, 0, 1, 0, 0, 0, 0, 0)};
      tbl[3]  = '{en:1'b1, exp:mk(2, 0, 1, 0, 0, 0, 0, 0)};
      tbl[4]  = '{en:1'b1, exp:mk(3, 0, 1, 0, 0, 0, 0, 0)};
      tbl[5]  = '{en:1'b1, exp:mk(4, 0, 0, 0, 0, 0, 0, 0)};
      tbl[6]  = '{en:1'b1, exp:mk(5, 0, 0, 1, 0, 0, 0, 0)};
      tbl[7]  = '{en:1'b0, exp:mk(5, 0, 0, 1, 0, 0, 0, 0)};
      tbl[8]  = '{en:1'b1, exp:mk(6, 0, 0, 1, 0, 0, 0, 0)};
      tbl[9]  = '{en:1'b1, exp:mk(7, 0, 0, 0, 0, 0, 0, 0)};
      tbl[10] = '{en:1'b1, exp:mk(0, 1, 1, 0, 0, 1, 0, 0)};

      bif.en = 1'b0;
      sif.en = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge vga_clk);
      #1;
      check("reset_big", samp_big(), mk(0, 0, 0, 1, 1, 0, 0, 0));
      check("reset_small", samp_sm(), mk(0, 0, 0, 0, 0, 0, 0, 0));
      reset_n = 1'b1;
      k = 0;

      // Startup vectors on the tiny generator
      for (int i = 0; i < 11; i++) begin
         tick(tbl[i].en);
         check($sformatf("vec%0d", i), samp_sm(), tbl[i].exp);
      end

      // First line of the full-size raster
      async_reset();
      ls_cnt = 0; ls_first = -1; ls_second = -1; blank_cnt = 0; hs_cnt = 0; hs_x = -1;
      for (int c = 1; c <= 801; c++) begin
         tick(1'b1);
         if (c == 1) check_int("fs_first_edge", int'(bif.frame_start), 1);
         if (bif.line_start) begin
            ls_cnt++;
            if (ls_first < 0) ls_first = c;
            else if (ls_second < 0) ls_second = c;
         end
         if (c <= 800) begin
            if (bif.blank) blank_cnt++;
            if (!bif.hs) begin
               hs_cnt++;
               if (hs_x < 0) hs_x = int'(bif.DrawX);
            end
         end
         if (c == 800) check_int("x_last", int'(bif.DrawX), 799);
      end
      check_int("ls_count", ls_cnt, 2);
      check_int("ls_first", ls_first, 1);
      check_int("ls_second", ls_second, 801);
      check_int("blank_per_line", blank_cnt, 640);
      check_int("hs_low_len", hs_cnt, 96);
      check_int("hs_low_start", hs_x, 656);
      check_int("x_wrap", int'(bif.DrawX), 0);
      check_int("y_step", int'(bif.DrawY), 1);

      // Stall at DrawX=655 for 37 cycles
      n = 0;
      while (bif.DrawX != 10'd655 && n < 1000) begin
         tick(1'b1);
         n++;
      end
      check_int("reach_655", int'(bif.DrawX), 655);
      frozen_bad = 0;
      for (int c = 0; c < 37; c++) begin
         tick(1'b0);
         if (bif.line_start || bif.frame_start || bif.DrawX != 10'd655 || bif.hs != 1'b1)
            frozen_bad++;
      end
      check_int("hold_frozen", frozen_bad, 0);
      tick(1'b1);
      check_int("hs_after_hold", int'(bif.hs), 0);
      check_int("x_after_hold", int'(bif.DrawX), 656);
      n = 0;
      while (!bif.line_start && n < 1000) begin
         tick(1'b1);
         n++;
      end
      check_int("line_len_enabled", k - 801, 800);

      // Mid-frame reset on the tiny raster, then 16 frames with random en
      n = 0;
      while (sif.DrawY != 10'd2 && n < 200) begin
         tick(1'b1);
         n++;
      end
      check_int("reach_small_y2", int'(sif.DrawY), 2);
      async_reset();
      tick(1'b1);
      check_int("fs_after_reset", int'(sif.frame_start), 1);
      fs_cnt = 1; vs_cnt = 0; wrap_seen = 0; guard = 0;
      prev_fc = int'(sif.frame_count);
      while (k < 769 && guard < 5000) begin
         e = ($urandom_range(0, 3) != 0);
         tick(e);
         guard++;
         if (e) begin
            if (sif.frame_start) fs_cnt++;
            if (sif.vs) vs_cnt++;
         end
         if (prev_fc == 15 && sif.frame_count == 4'd0) wrap_seen++;
         prev_fc = int'(sif.frame_count);
      end
      check_int("frames_reached", k, 769);
      check_int("fs_pulses", fs_cnt, 17);
      check_int("vs_active_cycles", vs_cnt, 128);
      check_int("fc_wrap_seen", wrap_seen, 1);
      check_int("fc_final", int'(sif.frame_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
